// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit RISC core: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath strobes from the state register, latched opcode and memory handshake.
module multicycle_controller #(
  parameter int unsigned EXT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExtw   = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpAddi = 4'h4;
  localparam logic [3:0] OpLw   = 4'h5;
  localparam logic [3:0] OpSw   = 4'h6;
  localparam logic [3:0] OpBeq  = 4'h7;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam int unsigned CntInitInt = (EXT_LAT > 1) ? EXT_LAT - 2 : 0;
  localparam logic [1:0]  CntInit    = CntInitInt[1:0];
  localparam logic        UseExtw    = (EXT_LAT > 1);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] dec_op;
  logic       dec_illegal;

  // Only the opcode field is decoded here; the operand fields go straight to the datapath.
  logic unused_instr;
  assign unused_instr = ^instr[11:0];

  assign dec_op      = instr[15:12];
  assign dec_illegal = dec_op[3] && (dec_op != OpHalt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      op_q    <= 4'h0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = 2'b00;
    illegal      = 1'b0;
    halted       = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        op_d = dec_op;
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = StFetch;
        end else if (dec_op == OpHalt) begin
          state_d = StHalt;
        end else if (UseExtw) begin
          cnt_d   = CntInit;
          state_d = StExtw;
        end else begin
          state_d = StExec;
        end
      end
      StExtw: begin
        if (cnt_q == 2'd0) begin
          state_d = StExec;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StExec: begin
        case (op_q)
          OpAdd, OpSub, OpAnd, OpOr: begin
            alu_op  = op_q[1:0];
            state_d = StWb;
          end
          OpAddi: begin
            alu_src_imm = 1'b1;
            state_d     = StWb;
          end
          OpLw, OpSw: begin
            alu_src_imm = 1'b1;
            state_d     = StMem;
          end
          OpBeq: begin
            alu_op = 2'b01;
            if (alu_zero) begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OpSw);
        if (mem_ready) begin
          state_d = (op_q == OpLw) ? StWb : StFetch;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        wb_sel    = (op_q == OpLw);
        state_d   = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  assign state = state_q;

endmodule
